// File: rtl/restoring_div_if.sv
`default_nettype none
// ============================================================================
// Module      : restoring_div_if
// Description : Start/busy/done handshake and operand/result bundle for the
//               restoring divider. The master drives the request and
//               operands. The slave (the divider) returns status and results.
//               Signals:
//                 start    - request, honoured only while busy is low
//                 dividend - 2W-bit unsigned dividend
//                 divisor  - W-bit unsigned divisor
//                 busy     - division in progress
//                 done     - one-cycle result-valid pulse
//                 q, r     - quotient / remainder, held until next completion
//                 ovf, dz  - quotient overflow / divide-by-zero flags
// Revision    : 1.0 - initial release
// ============================================================================
interface restoring_div_if #(
  parameter int W = 5
);
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   q;
  logic [W-1:0]   r;
  logic           ovf;
  logic           dz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, q, r, ovf, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, q, r, ovf, dz
  );
endinterface
`default_nettype wire

// File: rtl/restoring_div.sv
`default_nettype none
// ============================================================================
// Module      : restoring_div
// Description : Sequential unsigned restoring divider. It divides a 2W-bit
//               dividend by a W-bit divisor and retires one quotient bit per
//               clock. The result is a W-bit quotient and a W-bit remainder.
//               Ports:
//                 clk    - rising-edge clock
//                 rst    - synchronous active-high reset
//                 div_if - restoring_div_if.slave (start/operands in,
//                          busy/done/q/r/ovf/dz out)
//               Optional feature macro: WDIV_EARLY_EXIT_EN
//                 When it is defined, overflow or divide-by-zero requests
//                 skip the iteration phase. done then pulses in the cycle
//                 right after the accepting edge.
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_div #(
  parameter int W = 5
) (
  input  wire logic        clk,
  input  wire logic        rst,
  restoring_div_if.slave   div_if
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   rem_q, rem_d;   // partial remainder
  logic [W-1:0]   sh_q, sh_d;     // dividend low half shifting out, quotient shifting in
  logic [W-1:0]   dvs_q, dvs_d;   // captured divisor
  logic           err_q, err_d;   // overflow seen at accept
  logic           dzp_q, dzp_d;   // divide-by-zero seen at accept
  logic           done_q, done_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   r_q, r_d;
  logic           ovf_q, ovf_d;
  logic           dz_q, dz_d;

  // Error classification at accept. A zero divisor always satisfies the
  // high-half >= divisor test, so dz implies ovf without extra logic.
  logic           w_ovf_n;
  logic           w_dz_n;
  assign w_ovf_n = (div_if.dividend[2*W-1:W] >= div_if.divisor);
  assign w_dz_n  = (div_if.divisor == '0);

  // One restoring step. When the division cannot overflow, the subtracted
  // value always fits in W bits. The low-W-bit subtraction is therefore
  // exact, and T[W] is only needed for the compare.
  logic [W:0]     w_t;
  logic           w_ge;
  logic [W-1:0]   w_rem_next;
  logic [W-1:0]   w_sh_next;
  assign w_t        = {rem_q, sh_q[W-1]};
  assign w_ge       = (w_t >= {1'b0, dvs_q});
  assign w_rem_next = w_ge ? (w_t[W-1:0] - dvs_q) : w_t[W-1:0];
  assign w_sh_next  = {sh_q[W-2:0], w_ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    dvs_d   = dvs_q;
    err_d   = err_q;
    dzp_d   = dzp_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (div_if.start) begin
          dvs_d = div_if.divisor;
          rem_d = div_if.dividend[2*W-1:W];
          sh_d  = div_if.dividend[W-1:0];
          err_d = w_ovf_n;
          dzp_d = w_dz_n;
          cnt_d = '0;
`ifdef WDIV_EARLY_EXIT_EN
          if (w_ovf_n) begin
            done_d = 1'b1;
            q_d    = '1;
            r_d    = '0;
            ovf_d  = 1'b1;
            dz_d   = w_dz_n;
          end else begin
            state_d = RUN;
          end
`else
          state_d = RUN;
`endif
        end
      end

      RUN: begin
        rem_d = w_rem_next;
        sh_d  = w_sh_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (err_q) begin
            // The iteration result is meaningless on overflow and is dropped.
            q_d   = '1;
            r_d   = '0;
            ovf_d = 1'b1;
            dz_d  = dzp_q;
          end else begin
            q_d   = w_sh_next;
            r_d   = w_rem_next;
            ovf_d = 1'b0;
            dz_d  = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      dvs_q   <= '0;
      err_q   <= 1'b0;
      dzp_q   <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      dvs_q   <= dvs_d;
      err_q   <= err_d;
      dzp_q   <= dzp_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign div_if.busy = (state_q == RUN);
  assign div_if.done = done_q;
  assign div_if.q    = q_q;
  assign div_if.r    = r_q;
  assign div_if.ovf  = ovf_q;
  assign div_if.dz   = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_restoring_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_restoring_div
// Description : Directed self-checking bench for restoring_div (W=5).
//               It covers reset, a basic division, the full round trip,
//               overflow, divide-by-zero, back-to-back requests with start
//               held high, and reset in the middle of a division.
//               Latency is counted in clock edges after the accepting edge,
//               up to the edge after which done is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_restoring_div;

  localparam int W     = 5;
  localparam int BOUND = 40;
`ifdef WDIV_EARLY_EXIT_EN
  localparam int ERR_LAT  = 0;  // done in the cycle following the accepting edge
  localparam int ERR_BUSY = 0;
`else
  localparam int ERR_LAT  = W;
  localparam int ERR_BUSY = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  restoring_div_if #(.W(W)) dif ();

  restoring_div #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  always #5 clk = ~clk;

  // Issue one request and wait for done. This is stimulus only; callers do
  // the checks. lat = edges after the accepting edge until done is seen.
  // bcnt = samples with busy high.
  task automatic do_div(input logic [2*W-1:0] dd, input logic [W-1:0] dv,
                        output int lat, output int bcnt);
    dif.start    = 1'b1;
    dif.dividend = dd;
    dif.divisor  = dv;
    @(posedge clk); #1;
    dif.start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (dif.done !== 1'b1 && lat < BOUND) begin
      if (dif.busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dif.busy, dif.done, dif.q, dif.r, dif.ovf, dif.dz} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d ovf=%b dz=%b, want all zero",
               dif.busy, dif.done, dif.q, dif.r, dif.ovf, dif.dz);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", dif.busy, dif.done);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    do_div(10'd837, 5'd29, lat, bc);
    checks++;
    if (lat !== W) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, W); end
    checks++;
    if (bc !== W) begin errors++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, W); end
    checks++;
    if (dif.q !== 5'd28 || dif.r !== 5'd25 || dif.ovf !== 1'b0 || dif.dz !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d ovf=%b dz=%b want q=28 r=25 ovf=0 dz=0",
               dif.q, dif.r, dif.ovf, dif.dz);
    end
    @(posedge clk); #1;
    checks++;
    if (dif.done !== 1'b0 || dif.q !== 5'd28) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b q=%0d want done=0 q=28", dif.done, dif.q);
    end
  endtask

  task automatic test_round_trip();
    int lat, bc;
    int bad;
    bad = 0;
    for (int x = 1; x <= 31; x++) begin
      for (int y = 1; y <= 31; y++) begin
        do_div(10'(x * y), 5'(y), lat, bc);
        checks++;
        if (lat !== W || dif.q !== 5'(x) || dif.r !== 5'd0 || dif.ovf !== 1'b0 || dif.dz !== 1'b0) begin
          errors++;
          bad++;
          if (bad <= 10)
            $display("FAIL round_trip %0d/%0d: got q=%0d r=%0d ovf=%b dz=%b lat=%0d want q=%0d r=0 ovf=0 dz=0 lat=%0d",
                     x * y, y, dif.q, dif.r, dif.ovf, dif.dz, lat, x, W);
        end
      end
    end
    do_div(10'd961, 5'd31, lat, bc);
    checks++;
    if (dif.q !== 5'd31 || dif.r !== 5'd0 || dif.ovf !== 1'b0) begin
      errors++;
      $display("FAIL round_trip_max: got q=%0d r=%0d ovf=%b want q=31 r=0 ovf=0", dif.q, dif.r, dif.ovf);
    end
  endtask

  task automatic test_overflow();
    int lat, bc;
    do_div(10'd1000, 5'd31, lat, bc);
    checks++;
    if (dif.q !== 5'd31 || dif.r !== 5'd0 || dif.ovf !== 1'b1 || dif.dz !== 1'b0) begin
      errors++;
      $display("FAIL overflow_result: got q=%0d r=%0d ovf=%b dz=%b want q=31 r=0 ovf=1 dz=0",
               dif.q, dif.r, dif.ovf, dif.dz);
    end
    checks++;
    if (lat !== ERR_LAT) begin errors++; $display("FAIL overflow_latency: got %0d want %0d", lat, ERR_LAT); end
    checks++;
    if (bc !== ERR_BUSY) begin errors++; $display("FAIL overflow_busy_cycles: got %0d want %0d", bc, ERR_BUSY); end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    do_div(10'd100, 5'd0, lat, bc);
    checks++;
    if (dif.q !== 5'd31 || dif.r !== 5'd0 || dif.ovf !== 1'b1 || dif.dz !== 1'b1) begin
      errors++;
      $display("FAIL div_zero_result: got q=%0d r=%0d ovf=%b dz=%b want q=31 r=0 ovf=1 dz=1",
               dif.q, dif.r, dif.ovf, dif.dz);
    end
    checks++;
    if (lat !== ERR_LAT) begin errors++; $display("FAIL div_zero_latency: got %0d want %0d", lat, ERR_LAT); end
    // Return to a normal division right after an error.
    do_div(10'd837, 5'd29, lat, bc);
    checks++;
    if (dif.q !== 5'd28 || dif.r !== 5'd25 || dif.ovf !== 1'b0 || dif.dz !== 1'b0) begin
      errors++;
      $display("FAIL after_error_result: got q=%0d r=%0d ovf=%b dz=%b want 28 25 0 0",
               dif.q, dif.r, dif.ovf, dif.dz);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    // First request; start stays high and the operands change during RUN.
    dif.start = 1'b1; dif.dividend = 10'd837; dif.divisor = 5'd29;
    @(posedge clk); #1;
    dif.dividend = 10'd900; dif.divisor = 5'd30;
    lat = 0;
    while (dif.done !== 1'b1 && lat < BOUND) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== W || dif.q !== 5'd28 || dif.r !== 5'd25) begin
      errors++;
      $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d want q=28 r=25 lat=%0d", dif.q, dif.r, lat, W);
    end
    // start is still high, so the edge ending the done cycle accepts 900/30.
    @(posedge clk); #1;
    checks++;
    if (dif.busy !== 1'b1 || dif.done !== 1'b0 || dif.q !== 5'd28 || dif.r !== 5'd25) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b q=%0d r=%0d want busy=1 done=0 q=28 r=25",
               dif.busy, dif.done, dif.q, dif.r);
    end
    dif.start = 1'b0;
    lat = 0;
    while (dif.done !== 1'b1 && lat < BOUND) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat !== W || dif.q !== 5'd30 || dif.r !== 5'd0 || dif.ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got q=%0d r=%0d ovf=%b lat=%0d want q=30 r=0 ovf=0 lat=%0d",
               dif.q, dif.r, dif.ovf, lat, W);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    int seen;
    dif.start = 1'b1; dif.dividend = 10'd837; dif.divisor = 5'd29;
    @(posedge clk); #1;          // E0
    dif.start = 1'b0;
    @(posedge clk);              // E1
    @(posedge clk); #1;          // E2
    rst = 1'b1;
    @(posedge clk); #1;          // E3 with reset
    rst = 1'b0;
    checks++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.q !== 5'd0 || dif.r !== 5'd0 ||
        dif.ovf !== 1'b0 || dif.dz !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%0d r=%0d ovf=%b dz=%b want all zero",
               dif.busy, dif.done, dif.q, dif.r, dif.ovf, dif.dz);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (dif.done === 1'b1 || dif.busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d active cycles want 0", seen); end
    do_div(10'd837, 5'd29, lat, bc);
    checks++;
    if (lat !== W || dif.q !== 5'd28 || dif.r !== 5'd25 || dif.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fresh: got q=%0d r=%0d ovf=%b lat=%0d want q=28 r=25 ovf=0 lat=%0d",
               dif.q, dif.r, dif.ovf, lat, W);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_trip();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
